matrix_vector_gather: RTL and testbench
=======================================

MATRIX_VECTOR_GATHER -- requirements
Module: matrix_vector_gather

Interface
- REQ-001: Parameter VEC_W, default 256; width in bits of one column/row vector beat.
- REQ-002: Parameter NUM_VEC, default 16; beats per matrix; MAT_W = VEC_W*NUM_VEC (default 4096).
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: en  input  1  enable; starts collection from IDLE, gates beat acceptance in COLLECT.
- REQ-006: vec_in  input  VEC_W  signed vector beat; passed bit-exact, no arithmetic.
- REQ-007: vec_valid  input  1  producer asserts when vec_in is valid.
- REQ-008: vec_ready  output  1  block can accept a beat this cycle.
- REQ-009: Matrix  output  MAT_W  signed assembled matrix, registered.
- REQ-010: mat_valid  output  1  Matrix holds a complete, unconsumed matrix.
- REQ-011: mat_ack  input  1  consumer has taken Matrix.
- REQ-012: cnt  output  4 (log2 NUM_VEC)  index of next beat to be written.

Function
- REQ-013: FSM states IDLE, COLLECT, HOLD; exactly one active.
- REQ-014: IDLE: vec_ready=0; en=1 -> COLLECT next cycle with cnt=0.
- REQ-015: vec_ready SHALL be combinational: 1 only when state==COLLECT and en==1.
- REQ-016: Beat accepted on an edge where vec_valid && vec_ready; no other condition writes data.
- REQ-017: Beat k (k=cnt) written to slice [MAT_W-1-k*VEC_W -: VEC_W]; beat 0 lands in MSBs, beat NUM_VEC-1 in LSBs.
- REQ-018: Beats accumulate in an internal shadow register; Matrix output never shows partial data.
- REQ-019: Accepted beat with cnt<NUM_VEC-1: cnt <= cnt+1, stay COLLECT.
- REQ-020: Accepted beat with cnt==NUM_VEC-1: on same edge Matrix <= shadow with final beat merged, cnt <= 0, mat_valid <= 1, state -> HOLD; latency from final beat to mat_valid = 1 cycle.
- REQ-021: en low in COLLECT pauses: vec_ready=0, cnt and shadow retained; resumes at same cnt when en returns.
- REQ-022: HOLD: vec_ready=0, Matrix and mat_valid stable; vec_valid ignored.
- REQ-023: HOLD with mat_ack=1: mat_valid <= 0; next state COLLECT if en=1 that cycle else IDLE; cnt=0.
- REQ-024: mat_ack outside HOLD ignored.
- REQ-025: Matrix holds last completed value after mat_valid drops, until next completion overwrites it.
- REQ-026: Shadow not cleared between matrices; every slice is rewritten each pass.

Reset
- REQ-027: rst=1 at an edge: state IDLE, cnt=0, mat_valid=0, Matrix=0, shadow=0; overrides all other inputs same edge.
- REQ-028: rst mid-COLLECT discards partial beats; next matrix starts at beat 0.
- REQ-029: vec_ready=0 during and the cycle after reset (state IDLE).

Verification
- REQ-030: en=1, 16 back-to-back beats vec_in=k (k=0..15) -> one cycle after beat 15, mat_valid=1, Matrix[4095:3840]=0, Matrix[255:0]=15, each slice k = k.
- REQ-031: vec_valid toggled 1/0 each cycle, beats 0xA5..A5 x16 -> completion after 32 cycles, cnt advances only on accepted beats, Matrix all 0xA5.
- REQ-032: en dropped after beat 7 for 5 cycles -> vec_ready=0, cnt=8 held; resume -> beat 8 lands in Matrix[2047:1792].
- REQ-033: in HOLD drive vec_valid=1 with vec_in=all-ones for 10 cycles, mat_ack=0 -> Matrix unchanged, cnt=0; mat_ack=1 with en=1 -> mat_valid=0 next cycle, vec_ready=1.
- REQ-034: rst pulse after beat 9 -> mat_valid=0, Matrix=0, cnt=0; following 16 beats produce full matrix, no stale beats.
- REQ-035: negative values (vec_in=256'h8000...0001) -> reproduced bit-exact in the matching slice, no sign extension across slices.

Source files
------------

// File: rtl/matrix_vector_gather.sv
// matrix_vector_gather
//   Collects NUM_VEC vector beats of VEC_W bits into one MAT_W-bit matrix.
//   Beat 0 lands in the most significant slice and beat NUM_VEC-1 in the
//   least significant slice. Data is copied bit-exact, with no arithmetic.
//   Beats build up in a shadow register, so the Matrix output only ever
//   changes to a complete matrix.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   en           starts collection from IDLE; gates beat acceptance in COLLECT
//   vec_in       one vector beat (VEC_W bits, signed, copied bit-exact)
//   vec_valid    producer has a beat on vec_in
//   vec_ready    block accepts a beat this cycle (combinational)
//   Matrix       last completed matrix (registered)
//   mat_valid    Matrix holds a complete matrix that has not been acknowledged
//   mat_ack      consumer has taken Matrix (used only in HOLD)
//   cnt          index of the next beat to be written
//   o_dbg_state  current FSM state (0 IDLE, 1 COLLECT, 2 HOLD)
//
// Handshake: a beat transfers on a rising edge where vec_valid && vec_ready.
//   vec_valid may be asserted at any time. vec_ready depends only on the
//   state and en, never on vec_valid. A matrix is handed over while
//   mat_valid is high and completes on the edge where mat_ack is sampled high.

module matrix_vector_gather #(
    parameter int VEC_W   = 256,
    parameter int NUM_VEC = 16,
    parameter int MAT_W   = VEC_W * NUM_VEC,
    parameter int CNT_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [VEC_W-1:0]  vec_in,
    input  logic                     vec_valid,
    output logic                     vec_ready,
    output logic signed [MAT_W-1:0]  Matrix,
    output logic                     mat_valid,
    input  logic                     mat_ack,
    output logic [CNT_W-1:0]         cnt,
    output logic [1:0]               o_dbg_state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [MAT_W-1:0]  r_shadow;
    logic [MAT_W-1:0]  r_matrix;
    logic              r_mat_valid;

    logic              w_ready;
    logic              w_accept;
    logic [MAT_W-1:0]  w_merged;

    assign w_ready  = (r_state == S_COLLECT) && en;
    assign w_accept = vec_valid && w_ready;

    // Shadow with the incoming beat dropped into slice r_cnt. The final beat
    // is merged here so it can reach Matrix on the same edge it is accepted.
    always_comb begin
        w_merged = r_shadow;
        for (int k = 0; k < NUM_VEC; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_merged[MAT_W-1-k*VEC_W -: VEC_W] = vec_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_matrix    <= '0;
            r_mat_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_COLLECT;
                        r_cnt   <= '0;
                    end
                end
                S_COLLECT: begin
                    // With en low, w_accept is 0, so cnt and shadow hold.
                    if (w_accept) begin
                        r_shadow <= w_merged;
                        if (r_cnt == LAST_IDX) begin
                            r_matrix    <= w_merged;
                            r_mat_valid <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (mat_ack) begin
                        r_mat_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= en ? S_COLLECT : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign vec_ready   = w_ready;
    assign Matrix      = r_matrix;
    assign mat_valid   = r_mat_valid;
    assign cnt         = r_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matrix_vector_gather.sv
module tb_matrix_vector_gather;

    localparam int VEC_W   = 256;
    localparam int NUM_VEC = 16;
    localparam int MAT_W   = VEC_W * NUM_VEC;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst       = 1'b1;
    logic                     en        = 1'b0;
    logic signed [VEC_W-1:0]  vec_in    = '0;
    logic                     vec_valid = 1'b0;
    logic                     vec_ready;
    logic signed [MAT_W-1:0]  Matrix;
    logic                     mat_valid;
    logic                     mat_ack   = 1'b0;
    logic [3:0]               cnt;
    logic [1:0]               o_dbg_state;

    matrix_vector_gather #(.VEC_W(VEC_W), .NUM_VEC(NUM_VEC)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .vec_in      (vec_in),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .Matrix      (Matrix),
        .mat_valid   (mat_valid),
        .mat_ack     (mat_ack),
        .cnt         (cnt),
        .o_dbg_state (o_dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [MAT_W-1:0] exp_q[$];
    logic [VEC_W-1:0] beats[NUM_VEC];
    logic [MAT_W-1:0] last_exp;

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_vec(input string name, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // On a mismatch, report only the first differing slice to keep lines short.
    task automatic chk_mat(input string name, input logic [MAT_W-1:0] got, input logic [MAT_W-1:0] exp);
        logic [VEC_W-1:0] g;
        logic [VEC_W-1:0] e;
        int bad;
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            bad = -1;
            for (int k = NUM_VEC - 1; k >= 0; k--) begin
                g = got[MAT_W-1-k*VEC_W -: VEC_W];
                e = exp[MAT_W-1-k*VEC_W -: VEC_W];
                if (g !== e) bad = k;
            end
            if (bad < 0) bad = 0;
            g = got[MAT_W-1-bad*VEC_W -: VEC_W];
            e = exp[MAT_W-1-bad*VEC_W -: VEC_W];
            $display("FAIL %s: slice %0d got %h expected %h", name, bad, g, e);
        end
    endtask

    // Reference placement: beat k occupies [MAT_W-1-k*VEC_W -: VEC_W].
    function automatic logic [MAT_W-1:0] build_mat();
        logic [MAT_W-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_VEC; k++) m[MAT_W-1-k*VEC_W -: VEC_W] = beats[k];
        return m;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_expected();
        last_exp = build_mat();
        exp_q.push_back(last_exp);
    endtask

    // Back-to-back beats from beats[lo..hi]; cnt checked after each non-final beat.
    task automatic send_range(input int lo, input int hi, input string tag);
        for (int k = lo; k <= hi; k++) begin
            vec_valid = 1'b1;
            vec_in    = beats[k];
            step();
            if (k < NUM_VEC - 1 && (k == lo || k == hi))
                chk({tag, "_cnt"}, 64'(cnt), 64'(k + 1));
        end
        vec_valid = 1'b0;
    endtask

    task automatic ack(input logic en_after);
        mat_ack = 1'b1;
        en      = en_after;
        step();
        mat_ack = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            seen <= 1'b0;
        end else if (mat_valid && !seen) begin
            seen <= 1'b1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_matrix: got mat_valid=1 expected no pending matrix");
            end else begin
                chk_mat("scoreboard_matrix", Matrix, exp_q.pop_front());
            end
        end else if (!mat_valid) begin
            seen <= 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset: vec_ready low during reset and the cycle after.
        step();
        chk("rst_ready_during", 64'(vec_ready), 64'd0);
        en = 1'b1;              // reset must override en
        step();
        chk("rst_state_during", 64'(o_dbg_state), 64'd0);
        rst = 1'b0;
        en  = 1'b0;
        step();
        chk("rst_ready_after", 64'(vec_ready), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_mat_valid", 64'(mat_valid), 64'd0);
        chk_mat("rst_matrix", Matrix, '0);

        // Back-to-back beats with vec_in = k.
        en = 1'b1;
        step();
        chk("collect_ready", 64'(vec_ready), 64'd1);
        chk("collect_cnt0", 64'(cnt), 64'd0);
        for (int k = 0; k < NUM_VEC; k++) beats[k] = VEC_W'(k);
        push_expected();
        send_range(0, 14, "b2b");
        chk("b2b_no_early_valid", 64'(mat_valid), 64'd0);
        send_range(15, 15, "b2b");
        chk("b2b_latency_valid", 64'(mat_valid), 64'd1);
        chk("b2b_cnt_wrap", 64'(cnt), 64'd0);
        chk_vec("b2b_msb_slice", Matrix[4095:3840], VEC_W'(0));
        chk_vec("b2b_lsb_slice", Matrix[255:0], VEC_W'(15));

        // HOLD ignores vec_valid; Matrix stable until ack.
        vec_valid = 1'b1;
        vec_in    = '1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 0 || c == 9) begin
                chk_mat("hold_matrix_stable", Matrix, last_exp);
                chk("hold_cnt", 64'(cnt), 64'd0);
                chk("hold_ready", 64'(vec_ready), 64'd0);
                chk("hold_valid", 64'(mat_valid), 64'd1);
            end
        end
        vec_valid = 1'b0;
        ack(1'b1);
        chk("ack_valid_drop", 64'(mat_valid), 64'd0);
        chk("ack_ready_collect", 64'(vec_ready), 64'd1);
        chk_mat("ack_matrix_retained", Matrix, last_exp);

        // vec_valid toggling: only accepted beats advance cnt.
        for (int k = 0; k < NUM_VEC; k++) beats[k] = {32{8'hA5}};
        push_expected();
        for (int c = 0; c <= 30; c++) begin
            vec_valid = (c % 2 == 0);
            vec_in    = {32{8'hA5}};
            step();
            if (c < 30 && (c % 7 == 0 || c == 29))
                chk("toggle_cnt", 64'(cnt), 64'(c / 2 + 1));
        end
        vec_valid = 1'b0;
        chk("toggle_done_valid", 64'(mat_valid), 64'd1);
        ack(1'b0);
        chk("ack_to_idle_state", 64'(o_dbg_state), 64'd0);
        chk("ack_to_idle_ready", 64'(vec_ready), 64'd0);

        // en pause after beat 7; mat_ack outside HOLD ignored.
        en = 1'b1;
        step();
        for (int k = 0; k < NUM_VEC; k++) beats[k] = VEC_W'(100 + k);
        push_expected();
        send_range(0, 7, "pause");
        en        = 1'b0;
        mat_ack   = 1'b1;
        vec_valid = 1'b1;
        vec_in    = '1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0 || c == 4) begin
                chk("pause_ready", 64'(vec_ready), 64'd0);
                chk("pause_cnt_held", 64'(cnt), 64'd8);
            end
        end
        mat_ack   = 1'b0;
        vec_valid = 1'b0;
        en        = 1'b1;
        send_range(8, 15, "resume");
        chk("resume_done_valid", 64'(mat_valid), 64'd1);
        chk_vec("resume_beat8_slice", Matrix[2047:1792], VEC_W'(108));
        ack(1'b1);

        // Reset after beat 9 discards the partial matrix.
        for (int k = 0; k < NUM_VEC; k++) beats[k] = VEC_W'(32'hDEAD0 + k);
        send_range(0, 9, "stale");
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 64'(mat_valid), 64'd0);
        chk("midrst_cnt", 64'(cnt), 64'd0);
        chk("midrst_ready", 64'(vec_ready), 64'd0);
        chk_mat("midrst_matrix", Matrix, '0);
        step();
        for (int k = 0; k < NUM_VEC; k++) beats[k] = VEC_W'(200 + k);
        push_expected();
        send_range(0, 15, "fresh");
        chk("fresh_done_valid", 64'(mat_valid), 64'd1);
        ack(1'b1);

        // Negative pattern stays in its own slice.
        for (int k = 0; k < NUM_VEC; k++) beats[k] = '0;
        beats[3] = {1'b1, {(VEC_W-2){1'b0}}, 1'b1};
        beats[NUM_VEC-1] = {1'b1, {(VEC_W-1){1'b0}}};
        push_expected();
        send_range(0, 15, "neg");
        chk_vec("neg_slice3", Matrix[MAT_W-1-3*VEC_W -: VEC_W], {1'b1, {(VEC_W-2){1'b0}}, 1'b1});
        chk_vec("neg_slice2_clean", Matrix[MAT_W-1-2*VEC_W -: VEC_W], '0);
        chk_vec("neg_slice4_clean", Matrix[MAT_W-1-4*VEC_W -: VEC_W], '0);
        ack(1'b0);

        step();
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
